// File: rtl/mlp_eval_ctrl.sv
// Evaluation controller for the combinational Iris MLP: holds one sample on the
// classifier, samples its class REPS times after a settle delay, and majority-votes.
module mlp_eval_ctrl #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 4,
  parameter int REPS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  mlp_inp,
  input  logic [OUT_W-1:0] mlp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_class,
  output logic             out_mismatch,
  output logic             busy
);

  localparam int         NCODE       = 1 << OUT_W;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [2:0] REP_LAST    = 3'(REPS - 1);

  typedef enum logic [1:0] {IDLE, EVAL, VOTE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   inp_q, inp_d;
  logic [7:0]        settle_q, settle_d;
  logic [2:0]        rep_q, rep_d;
  logic [2:0]        cnt_q [NCODE];
  logic [2:0]        cnt_d [NCODE];
  logic [OUT_W-1:0]  first_q, first_d;
  logic              diff_q, diff_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_class_q, out_class_d;
  logic              out_mismatch_q, out_mismatch_d;

  logic [OUT_W-1:0]  win_cls;
  logic [2:0]        win_cnt;

  // Strict greater-than keeps the lowest code on a tie.
  always_comb begin
    win_cls = '0;
    win_cnt = cnt_q[0];
    for (int c = 1; c < NCODE; c++) begin
      if (cnt_q[c] > win_cnt) begin
        win_cnt = cnt_q[c];
        win_cls = OUT_W'(c);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    inp_d          = inp_q;
    settle_d       = settle_q;
    rep_d          = rep_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    diff_d         = diff_q;
    out_valid_d    = out_valid_q;
    out_class_d    = out_class_q;
    out_mismatch_d = out_mismatch_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          inp_d    = in_data;
          settle_d = '0;
          rep_d    = '0;
          diff_d   = 1'b0;
          for (int c = 0; c < NCODE; c++) cnt_d[c] = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d       = '0;
          rep_d          = rep_q + 3'd1;
          cnt_d[mlp_out] = cnt_q[mlp_out] + 3'd1;
          if (rep_q == 3'd0)
            first_d = mlp_out;
          else if (mlp_out != first_q)
            diff_d = 1'b1;
          if (rep_q == REP_LAST) state_d = VOTE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      VOTE: begin
        out_class_d    = win_cls;
        out_mismatch_d = diff_q;
        out_valid_d    = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      inp_q          <= '0;
      settle_q       <= '0;
      rep_q          <= '0;
      for (int c = 0; c < NCODE; c++) cnt_q[c] <= '0;
      first_q        <= '0;
      diff_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_class_q    <= '0;
      out_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      inp_q          <= inp_d;
      settle_q       <= settle_d;
      rep_q          <= rep_d;
      cnt_q          <= cnt_d;
      first_q        <= first_d;
      diff_q         <= diff_d;
      out_valid_q    <= out_valid_d;
      out_class_q    <= out_class_d;
      out_mismatch_q <= out_mismatch_d;
    end
  end

  assign in_ready     = (state_q == IDLE) && !rst;
  assign busy         = (state_q != IDLE);
  assign mlp_inp      = inp_q;
  assign out_valid    = out_valid_q;
  assign out_class    = out_class_q;
  assign out_mismatch = out_mismatch_q;

endmodule

// File: tb/tb_mlp_eval_ctrl.sv
// Bench for mlp_eval_ctrl: default instance plus a SETTLE=1/REPS=5 instance,
// checked every cycle against a cycle-count/majority-vote model.
module tb_mlp_eval_ctrl;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid     [NI];
  logic        in_ready     [NI];
  logic [15:0] in_data      [NI];
  logic [15:0] mlp_inp      [NI];
  logic [1:0]  mlp_out      [NI];
  logic        out_valid    [NI];
  logic        out_ready    [NI];
  logic [1:0]  out_class    [NI];
  logic        out_mismatch [NI];
  logic        busy         [NI];

  mlp_eval_ctrl u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .mlp_inp(mlp_inp[0]), .mlp_out(mlp_out[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_class(out_class[0]),
    .out_mismatch(out_mismatch[0]), .busy(busy[0])
  );

  mlp_eval_ctrl #(.SETTLE(1), .REPS(5)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .mlp_inp(mlp_inp[1]), .mlp_out(mlp_out[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_class(out_class[1]),
    .out_mismatch(out_mismatch[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_active [NI];
  bit          m_outv   [NI];
  int          m_t      [NI];
  logic [15:0] m_inp    [NI];
  logic [1:0]  m_class  [NI];
  bit          m_mis    [NI];
  logic [1:0]  cur_script  [NI][7];
  logic [1:0]  next_script [NI][7];

  function automatic int s_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int r_of(int i);
    return (i == 0) ? 3 : 5;
  endfunction

  task automatic check(string name, int i, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic do_vote(int i);
    int cnt [4];
    int best;
    bit mis;
    cnt  = '{default: 0};
    mis  = 1'b0;
    for (int k = 0; k < r_of(i); k++) begin
      cnt[cur_script[i][k]]++;
      if (cur_script[i][k] != cur_script[i][0]) mis = 1'b1;
    end
    best = 0;
    for (int c = 1; c < 4; c++) if (cnt[c] > cnt[best]) best = c;
    m_class[i] = 2'(best);
    m_mis[i]   = mis;
  endtask

  // Model update, classifier drive, then per-cycle comparison.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_active[i] = 1'b0; m_outv[i] = 1'b0; m_t[i] = 0;
        m_inp[i] = '0; m_class[i] = '0; m_mis[i] = 1'b0;
      end else if (!m_active[i]) begin
        if (in_valid[i]) begin
          m_active[i] = 1'b1; m_t[i] = 0; m_inp[i] = in_data[i];
          cur_script[i] = next_script[i];
        end
      end else if (m_outv[i]) begin
        if (out_ready[i]) begin
          m_active[i] = 1'b0; m_outv[i] = 1'b0;
          $display("txn inst=%0d data=%h class=%0d mismatch=%0d", i, m_inp[i], m_class[i], m_mis[i]);
        end
      end else begin
        m_t[i]++;
        if (m_t[i] == r_of(i) * s_of(i) + 1) begin
          m_outv[i] = 1'b1;
          do_vote(i);
        end
      end
    end
    #1;
    // Classifier: garbage in the first cycle of each settle window when SETTLE>1.
    for (int i = 0; i < NI; i++) begin
      if (m_active[i] && !m_outv[i] && m_t[i] < r_of(i) * s_of(i)) begin
        if (s_of(i) > 1 && (m_t[i] % s_of(i)) == 0) mlp_out[i] = 2'($urandom);
        else mlp_out[i] = cur_script[i][m_t[i] / s_of(i)];
      end else begin
        mlp_out[i] = 2'($urandom);
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check("in_ready", i, int'(in_ready[i]), int'(!m_active[i] && !rst));
      check("busy", i, int'(busy[i]), int'(m_active[i]));
      check("out_valid", i, int'(out_valid[i]), int'(m_outv[i]));
      check("mlp_inp", i, int'(mlp_inp[i]), int'(m_inp[i]));
      check("out_class", i, int'(out_class[i]), int'(m_class[i]));
      check("out_mismatch", i, int'(out_mismatch[i]), int'(m_mis[i]));
    end
  end

  task automatic set_script(int i, int a, int b, int c, int d, int e);
    next_script[i][0] = 2'(a); next_script[i][1] = 2'(b); next_script[i][2] = 2'(c);
    next_script[i][3] = 2'(d); next_script[i][4] = 2'(e);
    next_script[i][5] = 2'd0;  next_script[i][6] = 2'd0;
  endtask

  task automatic run_txn(int i, logic [15:0] data, int exp_cls, int exp_mis, int exp_lat, int hold);
    int lat;
    @(negedge clk);
    in_valid[i] = 1'b1; in_data[i] = data; out_ready[i] = 1'b0;
    @(posedge clk); #3;
    check("accept_busy", i, int'(busy[i]), 1);
    @(negedge clk);
    in_valid[i] = 1'b0; in_data[i] = 16'($urandom);
    lat = 1;
    @(posedge clk); #3;
    while (!out_valid[i] && lat < 200) begin
      @(posedge clk); #3;
      lat++;
    end
    check("latency", i, lat, exp_lat);
    check("lit_class", i, int'(out_class[i]), exp_cls);
    check("lit_mismatch", i, int'(out_mismatch[i]), exp_mis);
    repeat (hold) begin
      @(negedge clk);
      in_valid[i] = 1'b1; in_data[i] = 16'($urandom);
    end
    @(posedge clk); #3;
    check("hold_valid", i, int'(out_valid[i]), 1);
    check("hold_inp", i, int'(mlp_inp[i]), int'(data));
    check("hold_class", i, int'(out_class[i]), exp_cls);
    @(negedge clk);
    in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    @(posedge clk); #3;
    check("hs_valid_drop", i, int'(out_valid[i]), 0);
    check("hs_ready_back", i, int'(in_ready[i]), 1);
    @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  task automatic rand_drive(int i, int n);
    int base;
    repeat (n) begin
      @(negedge clk);
      in_valid[i]  = ($urandom_range(0, 2) == 0);
      in_data[i]   = 16'($urandom);
      out_ready[i] = 1'($urandom_range(0, 1));
      if (!m_active[i]) begin
        base = $urandom_range(0, 3);
        for (int k = 0; k < 7; k++)
          next_script[i][k] = ($urandom_range(0, 2) != 0) ? 2'(base) : 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    repeat (30) @(negedge clk);
    out_ready[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b0; mlp_out[i] = '0;
      set_script(i, 0, 0, 0, 0, 0);
    end
    repeat (3) @(negedge clk);
    check("rst_out_valid", 0, int'(out_valid[0]), 0);
    check("rst_mlp_inp", 0, int'(mlp_inp[0]), 0);
    check("rst_in_ready", 0, int'(in_ready[0]), 0);
    check("rst_busy", 1, int'(busy[1]), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_script(0, 2, 2, 2, 0, 0);
    run_txn(0, 16'h8A2B, 2, 0, 13, 0);
    set_script(0, 1, 2, 1, 0, 0);
    run_txn(0, 16'h1357, 1, 1, 13, 20);
    set_script(0, 2, 0, 1, 0, 0);
    run_txn(0, 16'hBEEF, 0, 1, 13, 2);

    // Reset in the middle of an evaluation
    set_script(0, 2, 2, 2, 0, 0);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 16'h4242;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 0, int'(out_valid[0]), 0);
    check("mid_rst_inp", 0, int'(mlp_inp[0]), 0);
    check("mid_rst_busy", 0, int'(busy[0]), 0);
    check("mid_rst_ready", 0, int'(in_ready[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    set_script(0, 3, 1, 3, 0, 0);
    run_txn(0, 16'h0F0F, 3, 1, 13, 0);

    set_script(1, 3, 3, 0, 3, 0);
    run_txn(1, 16'hCAFE, 3, 1, 6, 3);

    fork
      rand_drive(0, 600);
      rand_drive(1, 600);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
